fb_rect_reader: RTL and testbench
=================================

# fb_rect_reader

Framebuffer rectangle readback engine. It reads a rectangular region of an 8-bit palette-indexed VRAM (320x180, row-major, address = SCREEN_WIDTH*y + x) through a registered-output single-port SRAM read port. It emits the pixels in raster order on a valid/ready stream with row and frame markers. It is the read-side counterpart to the sprite/background blitter that writes rectangles into VRAM, and it feeds capture, DMA or sprite-copy consumers.

## Interface
- ADDR_WIDTH, 16, VRAM address width
- DATA_WIDTH, 8, bits per pixel
- SCREEN_WIDTH, 320, pixels per row
- SCREEN_HEIGHT, 180, rows
- i_clk  in  1  system clock; all logic on rising edge
- i_rst_n  in  1  reset; asynchronous assert, active-low (synchronous deassert handled upstream)
- i_start  in  1  request strobe; sampled only in IDLE
- i_x / i_y  in  10 / 9  rectangle origin
- i_w / i_h  in  10 / 9  rectangle width / height in pixels
- o_busy  out  1  high from accepted start until o_done
- o_done  out  1  one-cycle pulse, transfer complete
- o_err  out  1  one-cycle pulse, request rejected
- o_addr  out  ADDR_WIDTH  VRAM read address
- o_rd  out  1  read strobe; i_data valid exactly one cycle later
- i_data  in  DATA_WIDTH  VRAM read data
- o_tdata  out  DATA_WIDTH  pixel
- o_tvalid / i_tready  out / in  1  stream handshake; a beat transfers when both are high
- o_tlast  out  1  marks the last pixel of each row
- o_tuser  out  1  marks the first pixel of the rectangle

## Operation
- States: IDLE, READ (issuing reads), DRAIN (all reads issued, buffer not empty).
- In IDLE, i_start=1 latches x/y/w/h and validates them:
  - Reject if w==0, h==0, x+w>SCREEN_WIDTH or y+h>SCREEN_HEIGHT. Rejection pulses o_err next cycle, stays in IDLE, issues no o_rd and no o_done.
  - Otherwise enter READ with o_busy=1.
- Addressing is incremental: row_base starts at SCREEN_WIDTH*y+x (one multiply at start), and o_addr = row_base+col. At the row end, col returns to 0 and row_base += SCREEN_WIDTH. Arithmetic is done at ADDR_WIDTH+1 bits, so no wrap is possible inside a valid rectangle.
- Output path is a 2-entry buffer (skid) holding {data,last,user}.
  - o_rd is issued only when occupancy + in-flight read < 2, counting a same-cycle pop.
  - The buffer never overflows, and no read is discarded.
- When o_tvalid=1 and i_tready=0, o_tdata/o_tlast/o_tuser hold stable.
- Transitions:
  - READ→DRAIN after the read of the last pixel (col=w-1, row=h-1).
  - DRAIN→IDLE when the final beat transfers; o_done pulses the next cycle and o_busy drops with it.
- i_start while busy is ignored, with no error.
- i_rst_n low at any time immediately forces IDLE and zeroes all outputs and the buffer. An in-flight read is dropped.
- Reset value of every output is 0.

## Timing
- Start sampled at edge N. The first o_rd is high in cycle N+1, i_data is captured at N+2, and o_tvalid is high from N+3.
- With i_tready held high, throughput is 1 pixel/cycle. For an accepted request, the final transfer is at N+2+w*h, and o_done is high in the following cycle.
- Backpressure stalls reads within 1 cycle. There is no bubble on release once the buffer is non-empty.
- o_err is high in cycle N+1 only.
- A new start is accepted in the cycle o_done is high (state is IDLE).

## Configuration
- FB_READER_CLIP_EN defined:
  - Over-edge rectangles are clipped: w'=min(w,SCREEN_WIDTH-x), h'=min(h,SCREEN_HEIGHT-y).
  - Reject only if w==0, h==0, x>=SCREEN_WIDTH or y>=SCREEN_HEIGHT.
  - o_tlast/o_done follow the clipped size.
- Undefined: over-edge rectangles are rejected with o_err as above. Clip logic is absent.

## Test plan
- VRAM model data=addr[7:0]. x=0,y=0,w=4,h=2, i_tready=1 → 8 beats: 0,1,2,3,64,65,66,67. o_tuser on beat 1; o_tlast on beats 4 and 8; o_done 1 cycle after beat 8; first o_tvalid 3 cycles after start.
- x=316,y=179,w=4,h=1, i_tready toggling 1/0 each cycle → o_addr 57596..57599. Data is stable while stalled, exactly 4 beats, no duplicates.
- x=300,y=0,w=32,h=1:
  - Without macro: o_err one cycle, zero o_rd, o_busy never high.
  - With FB_READER_CLIP_EN: 20 beats, o_tlast on beat 20.
- w=0 (any x,y) → o_err, no o_rd. Start during busy (second i_start mid-transfer) → ignored; beat count unchanged.
- Assert i_rst_n=0 after 5 beats of a 4x4 read → all outputs 0 in the same cycle. After release, 2x1 read at (10,10) → beats for addrs 3210,3211, then o_done.
- i_tready=0 for 20 cycles after start → exactly 2 reads issued, o_tvalid held. Release → remaining pixels stream at 1/cycle.

Source files
------------

// File: rtl/fb_rect_reader.sv
// fb_rect_reader: streams a rectangle of palette-indexed VRAM in raster order on a valid/ready stream.
// Define FB_READER_CLIP_EN to clip over-edge rectangles instead of rejecting them.
module fb_rect_reader #(
   parameter int ADDR_WIDTH    = 16,
   parameter int DATA_WIDTH    = 8,
   parameter int SCREEN_WIDTH  = 320,
   parameter int SCREEN_HEIGHT = 180
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [9:0]            i_x,
   input  logic [8:0]            i_y,
   input  logic [9:0]            i_w,
   input  logic [8:0]            i_h,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic                  o_rd,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_tdata,
   output logic                  o_tvalid,
   input  logic                  i_tready,
   output logic                  o_tlast,
   output logic                  o_tuser
);
   localparam int AW = ADDR_WIDTH + 1;
   localparam int EW = DATA_WIDTH + 2;
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
   state_t state, state_nx;
   logic [AW-1:0] row_base, addr_full;
   logic [9:0] col, w_q, w_eff;
   logic [8:0] row, h_q, h_eff;
   logic ok, accept, last_col, last_row, pop, push, fin;
   logic inf, inf_last, inf_user;
   logic [1:0] cnt;
   logic [EW-1:0] e0, e1, pd;
   always_comb begin
`ifdef FB_READER_CLIP_EN
      ok = i_w != 10'd0 && i_h != 9'd0 && i_x < 10'(SCREEN_WIDTH) && i_y < 9'(SCREEN_HEIGHT);
      w_eff = (i_w > 10'(SCREEN_WIDTH) - i_x) ? 10'(SCREEN_WIDTH) - i_x : i_w;
      h_eff = (i_h > 9'(SCREEN_HEIGHT) - i_y) ? 9'(SCREEN_HEIGHT) - i_y : i_h;
`else
      ok = i_w != 10'd0 && i_h != 9'd0 && 11'(i_x) + 11'(i_w) <= 11'(SCREEN_WIDTH)
           && 10'(i_y) + 10'(i_h) <= 10'(SCREEN_HEIGHT);
      w_eff = i_w;
      h_eff = i_h;
`endif
   end
   assign accept    = state == IDLE && i_start && ok;
   assign last_col  = col == w_q - 10'd1;
   assign last_row  = row == h_q - 9'd1;
   assign o_tvalid  = cnt != 2'd0;
   assign pop       = o_tvalid && i_tready;
   assign push      = inf;
   assign fin       = state == DRAIN && pop && cnt == 2'd1 && !inf;
   assign pd        = {i_data, inf_last, inf_user};
   assign addr_full = row_base + AW'(col);
   // Saturate rather than wrap; unreachable for any accepted rectangle
   assign o_addr    = addr_full[AW-1] ? '1 : addr_full[ADDR_WIDTH-1:0];
   assign {o_tdata, o_tlast, o_tuser} = e0;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state <= IDLE;
      else state <= state_nx;
   always_comb
      state_nx = accept ? READ
               : (state == READ && o_rd && last_col && last_row) ? DRAIN
               : fin ? IDLE : state;
   // A read may issue only if its data is guaranteed a buffer slot, counting this cycle's pop
   always_comb begin
      o_busy = state != IDLE;
      o_rd   = state == READ && 3'(cnt) + 3'(inf) - 3'(pop) < 3'd2;
   end
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         o_err    <= 1'b0;
         o_done   <= 1'b0;
         w_q      <= '0;
         h_q      <= '0;
         col      <= '0;
         row      <= '0;
         row_base <= '0;
         inf      <= 1'b0;
         inf_last <= 1'b0;
         inf_user <= 1'b0;
         cnt      <= '0;
         e0       <= '0;
         e1       <= '0;
      end else begin
         o_err  <= state == IDLE && i_start && !ok;
         o_done <= fin;
         if (accept) begin
            w_q      <= w_eff;
            h_q      <= h_eff;
            col      <= '0;
            row      <= '0;
            row_base <= AW'(SCREEN_WIDTH) * AW'(i_y) + AW'(i_x);
         end else if (o_rd) begin
            col <= last_col ? '0 : col + 10'd1;
            if (last_col) begin
               row      <= row + 9'd1;
               row_base <= row_base + AW'(SCREEN_WIDTH);
            end
         end
         inf      <= o_rd;
         inf_last <= last_col;
         inf_user <= col == 10'd0 && row == 9'd0;
         cnt      <= cnt + 2'(push) - 2'(pop);
         if (pop || push) e0 <= pop ? (cnt == 2'd2 ? e1 : pd) : (cnt == 2'd0 ? pd : e0);
         if (push && cnt - 2'(pop) == 2'd1) e1 <= pd;
      end
endmodule

// File: tb/tb_fb_rect_reader.sv
// tb_fb_rect_reader: directed checks of fb_rect_reader against a VRAM model returning addr[7:0].
// Honours FB_READER_CLIP_EN to select the expected over-edge behaviour.
module tb_fb_rect_reader;
   logic i_clk = 0, i_rst_n = 0, i_start = 0, i_tready = 1;
   logic [9:0] i_x = 0, i_w = 0;
   logic [8:0] i_y = 0, i_h = 0;
   logic [7:0] i_data = 0;
   logic o_busy, o_done, o_err, o_rd, o_tvalid, o_tlast, o_tuser;
   logic [15:0] o_addr;
   logic [7:0] o_tdata;
   int tests = 0, fails = 0, cyc = 0;
   int n_start, n_rd, n_err, n_done, err_cyc, done_cyc, first_v, stall_bad, busy_seen;
   int beats[$], bcyc[$], addrs[$];
   bit lasts[$], users[$];
   logic held_v = 0;
   logic [9:0] held;

   always #5 i_clk = ~i_clk;

   fb_rect_reader dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_x(i_x), .i_y(i_y), .i_w(i_w), .i_h(i_h),
      .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_addr(o_addr), .o_rd(o_rd), .i_data(i_data),
      .o_tdata(o_tdata), .o_tvalid(o_tvalid), .i_tready(i_tready), .o_tlast(o_tlast), .o_tuser(o_tuser)
   );

   always @(posedge i_clk) begin
      cyc <= cyc + 1;
      if (o_rd) i_data <= o_addr[7:0];
   end

   always @(negedge i_clk) begin
      if (o_tvalid && held_v && {o_tdata, o_tlast, o_tuser} !== held) stall_bad++;
      held_v = o_tvalid && !i_tready;
      held = {o_tdata, o_tlast, o_tuser};
      if (o_tvalid && first_v < 0) first_v = cyc;
      if (o_tvalid && i_tready) begin
         beats.push_back(int'(o_tdata));
         bcyc.push_back(cyc);
         lasts.push_back(o_tlast);
         users.push_back(o_tuser);
      end
      if (o_rd) begin
         n_rd++;
         addrs.push_back(int'(o_addr));
      end
      if (o_err) begin
         n_err++;
         err_cyc = cyc;
      end
      if (o_done) begin
         n_done++;
         done_cyc = cyc;
      end
      if (o_busy) busy_seen = 1;
   end

   task automatic chk(input string tag, input int got, input int exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clear();
      beats.delete(); bcyc.delete(); addrs.delete(); lasts.delete(); users.delete();
      n_rd = 0; n_err = 0; n_done = 0; err_cyc = -1; done_cyc = -1; first_v = -1;
      stall_bad = 0; busy_seen = 0; held_v = 0;
   endtask

   task automatic start_req(input int x, input int y, input int w, input int h);
      clear();
      i_x = 10'(x); i_y = 9'(y); i_w = 10'(w); i_h = 9'(h);
      i_start = 1;
      n_start = cyc + 1;
      tick();
      i_start = 0;
   endtask

   // mode 0: ready held high, mode 1: ready toggles every cycle
   task automatic wait_end(input int mode);
      int k = 0;
      while (n_done == 0 && n_err == 0 && k < 400) begin
         i_tready = (mode == 1) ? ~i_tready : 1'b1;
         tick();
         k++;
      end
      i_tready = 1;
      repeat (3) tick();
      chk("completion_bound", int'(k < 400), 1);
   endtask

   initial begin
      int exp1[8] = '{0, 1, 2, 3, 64, 65, 66, 67};
      int exp_bp[8] = '{64, 65, 66, 67, 128, 129, 130, 131};
      int nl, k;
      clear();
      #1;
      tests++;
      assert ({o_busy, o_done, o_err, o_rd, o_tvalid, o_tlast, o_tuser, o_tdata, o_addr} === 31'd0) else begin
         fails++;
         $error("FAIL reset_outputs: got %b expected 0", {o_busy, o_done, o_err, o_rd, o_tvalid, o_tlast, o_tuser, o_tdata, o_addr});
      end
      repeat (2) tick();
      i_rst_n = 1;
      tick();

      // 4x2 at origin, full throughput
      start_req(0, 0, 4, 2);
      wait_end(0);
      chk("t1_beats", beats.size(), 8);
      for (int i = 0; i < 8 && i < beats.size(); i++) begin
         chk($sformatf("t1_data%0d", i), beats[i], exp1[i]);
         chk($sformatf("t1_user%0d", i), int'(users[i]), int'(i == 0));
         chk($sformatf("t1_last%0d", i), int'(lasts[i]), int'(i == 3 || i == 7));
      end
      chk("t1_first_valid", first_v, n_start + 2);
      if (bcyc.size() == 8) chk("t1_last_beat_cycle", bcyc[7], n_start + 9);
      chk("t1_done_cycle", done_cyc, n_start + 10);
      chk("t1_done_count", n_done, 1);
      chk("t1_err_count", n_err, 0);
      chk("t1_busy", busy_seen, 1);

      // bottom-right corner with toggling ready
      start_req(316, 179, 4, 1);
      wait_end(1);
      chk("t2_rd_count", n_rd, 4);
      for (int i = 0; i < 4 && i < addrs.size(); i++) chk($sformatf("t2_addr%0d", i), addrs[i], 57596 + i);
      chk("t2_beats", beats.size(), 4);
      for (int i = 0; i < 4 && i < beats.size(); i++) chk($sformatf("t2_data%0d", i), beats[i], 252 + i);
      chk("t2_stall_stable", stall_bad, 0);
      chk("t2_done_count", n_done, 1);

      // over-edge rectangle
      start_req(300, 0, 32, 1);
      wait_end(0);
`ifdef FB_READER_CLIP_EN
      chk("t3_beats", beats.size(), 20);
      chk("t3_err_count", n_err, 0);
      nl = 0;
      for (int i = 0; i < beats.size(); i++) begin
         chk($sformatf("t3_data%0d", i), beats[i], (300 + i) & 255);
         nl += int'(lasts[i]);
      end
      chk("t3_last_count", nl, 1);
      if (lasts.size() == 20) chk("t3_last_on_20", int'(lasts[19]), 1);
      chk("t3_done_count", n_done, 1);
`else
      chk("t3_err_count", n_err, 1);
      chk("t3_err_cycle", err_cyc, n_start);
      chk("t3_rd_count", n_rd, 0);
      chk("t3_busy", busy_seen, 0);
      chk("t3_done_count", n_done, 0);
`endif

      // zero width
      start_req(5, 5, 0, 3);
      wait_end(0);
      chk("t4_err_count", n_err, 1);
      chk("t4_err_cycle", err_cyc, n_start);
      chk("t4_rd_count", n_rd, 0);
      chk("t4_done_count", n_done, 0);

      // second start while busy must be ignored
      start_req(0, 0, 4, 2);
      repeat (3) tick();
      i_x = 0; i_y = 0; i_w = 1; i_h = 1; i_start = 1;
      tick();
      i_start = 0;
      wait_end(0);
      chk("t5_beats", beats.size(), 8);
      chk("t5_done_count", n_done, 1);
      chk("t5_err_count", n_err, 0);
      if (beats.size() == 8) chk("t5_data7", beats[7], 67);

      // backpressure: ready low for 20 cycles after start
      i_tready = 0;
      start_req(0, 1, 4, 2);
      repeat (19) tick();
      chk("t6_rd_while_stalled", n_rd, 2);
      chk("t6_valid_held", int'(o_tvalid), 1);
      chk("t6_beats_while_stalled", beats.size(), 0);
      wait_end(0);
      chk("t6_beats", beats.size(), 8);
      for (int i = 0; i < 8 && i < beats.size(); i++) chk($sformatf("t6_data%0d", i), beats[i], exp_bp[i]);
      if (bcyc.size() == 8) chk("t6_stream_span", bcyc[7] - bcyc[0], 7);
      chk("t6_stall_stable", stall_bad, 0);
      chk("t6_done_count", n_done, 1);

      // reset in the middle of a 4x4 transfer
      start_req(0, 0, 4, 4);
      k = 0;
      while (beats.size() < 5 && k < 100) begin
         tick();
         k++;
      end
      chk("t7_reach_5_beats", int'(k < 100), 1);
      i_rst_n = 0;
      #1;
      tests++;
      assert ({o_busy, o_done, o_err, o_rd, o_tvalid, o_tlast, o_tuser, o_tdata, o_addr} === 31'd0) else begin
         fails++;
         $error("FAIL t7_reset_outputs: got %b expected 0", {o_busy, o_done, o_err, o_rd, o_tvalid, o_tlast, o_tuser, o_tdata, o_addr});
      end
      repeat (2) tick();
      i_rst_n = 1;
      tick();
      start_req(10, 10, 2, 1);
      wait_end(0);
      chk("t7_rd_count", n_rd, 2);
      for (int i = 0; i < 2 && i < addrs.size(); i++) chk($sformatf("t7_addr%0d", i), addrs[i], 3210 + i);
      chk("t7_beats", beats.size(), 2);
      for (int i = 0; i < 2 && i < beats.size(); i++) chk($sformatf("t7_data%0d", i), beats[i], (3210 + i) & 255);
      chk("t7_done_count", n_done, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
